// File: rtl/mm_pkg.sv
// Shared constants for the matrix-multiply datapath and its controller.
package mm_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 18;
  localparam int DIM    = 4;
  localparam int IDX_W  = 2;

  // Column sizes are carried mod 4 (4 encoded as 0); size-1 wraps to the last valid index.
  function automatic logic [IDX_W-1:0] last_idx(input logic [IDX_W-1:0] size);
    return IDX_W'(size - 1'b1);
  endfunction

endpackage

// File: rtl/mm_mac.sv
// Combinational multiply-accumulate: signed product, sign-extended, added to the running sum.
module mm_mac
  import mm_pkg::*;
#(
  parameter int DATA_W = mm_pkg::DATA_W,
  parameter int ACC_W  = mm_pkg::ACC_W
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic                     en,
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [2*DATA_W-1:0] prod_p0;

  // Widen the full-precision product to accumulator width; the sum itself wraps.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [2*DATA_W-1:0] p);
    return ACC_W'(p);
  endfunction

  // Product and accumulate in one combinational step; a disabled MAC adds nothing.
  always_comb begin
    prod_p0 = a * b;
    sum     = acc_in + (en ? sext_prod(prod_p0) : '0);
  end

endmodule

// File: rtl/mm_datapath.sv
// Matrix-multiply datapath: two element stores, a shared write pointer, and a MAC/accumulator
// stepped by an external controller through busy/valid/is_legal/change_row.
module mm_datapath
  import mm_pkg::*;
#(
  parameter int DATA_W = mm_pkg::DATA_W,
  parameter int ACC_W  = mm_pkg::ACC_W,
  parameter int DIM    = mm_pkg::DIM
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     col_end,
  input  logic                     row_end,
  input  logic                     M1_wen,
  input  logic                     M2_wen,
  input  logic                     busy,
  input  logic                     valid,
  input  logic                     is_legal,
  input  logic                     change_row,
  input  logic [IDX_W-1:0]         M1_col_size,
  input  logic [IDX_W-1:0]         M2_col_size,
  output logic [IDX_W-1:0]         M1_row_idx,
  output logic [IDX_W-1:0]         M1_col_idx,
  output logic [IDX_W-1:0]         M2_col_idx,
  output logic signed [ACC_W-1:0]  out_data
);

  logic signed [DATA_W-1:0] m1 [DIM][DIM];
  logic signed [DATA_W-1:0] m2 [DIM][DIM];
  logic [IDX_W-1:0]         wr_row;
  logic [IDX_W-1:0]         wr_col;
  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [ACC_W-1:0]  mac_sum;
  logic                     mac_en;

  // Indices past the current matrix sizes would read stale store entries; such terms add zero.
  assign mac_en = (M1_col_idx <= last_idx(M1_col_size)) &&
                  (M2_col_idx <= last_idx(M2_col_size));

  mm_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .a      (m1[M1_row_idx][M1_col_idx]),
    .b      (m2[M1_col_idx][M2_col_idx]),
    .en     (mac_en),
    .acc_in (acc_p1),
    .sum    (mac_sum)
  );

  // Result is presented only on a legal valid cycle, one cycle after the last MAC.
  assign out_data = (valid && is_legal) ? acc_p1 : '0;

  // Store loading: row-major writes through the shared pointer; frozen while computing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          m1[r][c] <= '0;
          m2[r][c] <= '0;
        end
      end
      wr_row <= '0;
      wr_col <= '0;
    end else if (busy) begin
      wr_row <= '0;
      wr_col <= '0;
    end else if (M1_wen || M2_wen) begin
      if (M1_wen) m1[wr_row][wr_col] <= in_data;
      if (M2_wen) m2[wr_row][wr_col] <= in_data;
      if (!col_end) begin
        wr_col <= wr_col + IDX_W'(1);
      end else if (!row_end) begin
        wr_col <= '0;
        wr_row <= wr_row + IDX_W'(1);
      end else begin
        wr_col <= '0;
        wr_row <= '0;
      end
    end
  end

  // Compute sequencing: accumulate on busy cycles, emit and step the output index on valid cycles.
  always_ff @(posedge clk) begin
    if (rst || !busy) begin
      acc_p1     <= '0;
      M1_row_idx <= '0;
      M1_col_idx <= '0;
      M2_col_idx <= '0;
    end else if (valid) begin
      acc_p1     <= '0;
      M1_col_idx <= '0;
      if (!is_legal) begin
        M1_row_idx <= '0;
        M2_col_idx <= '0;
      end else if (change_row) begin
        M2_col_idx <= '0;
        M1_row_idx <= M1_row_idx + IDX_W'(1);
      end else begin
        M2_col_idx <= M2_col_idx + IDX_W'(1);
      end
    end else begin
      acc_p1     <= mac_sum;
      M1_col_idx <= M1_col_idx + IDX_W'(1);
    end
  end

endmodule
